fifo_rd_ctrl: RTL and testbench

Read-domain controller for the asynchronous FIFO. It consumes the write pointer after the two-flop write-to-read synchronizer and owns the read-side state:
- binary/Gray read pointer
- registered empty and almost-empty flags
- readable fill level
- read-data-valid strobe
- underflow detection

Its Gray read pointer output feeds the read-to-write synchronizer in the opposite direction, and its binary address drives the dual-port memory read port.

---
 rtl/fifo_rd_ctrl.sv | 75 +++++++
 tb/tb_fifo_rd_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: binary/Gray read pointer,
// registered empty/almost-empty flags, readable level and read/underflow strobes.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  RCLK,
   input  logic                  RRSTn,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   wp2_rpt,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rpt,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  rd_valid,
   output logic                  underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] rbin_r;
   logic          accept_s;
   logic [PW-1:0] rbin_next_s;
   logic [PW-1:0] rgray_next_s;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] level_next_s;

   // Next-state pointer, level and flag inputs; the flags see the current wp2_rpt
   always_comb begin
      accept_s     = rd_en & ~empty;
      rbin_next_s  = rbin_r + {{ADDR_WIDTH{1'b0}}, accept_s};
      rgray_next_s = bin2gray(rbin_next_s);
      wbin_s       = gray2bin(wp2_rpt);
      level_next_s = wbin_s - rbin_next_s;
   end

   // Read-side state register; every output is taken straight from here
   always_ff @(posedge RCLK or negedge RRSTn) begin
      if (!RRSTn) begin
         rbin_r       <= {PW{1'b0}};
         rpt          <= {PW{1'b0}};
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= {PW{1'b0}};
         rd_valid     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         rbin_r       <= rbin_next_s;
         rpt          <= rgray_next_s;
         empty        <= (rgray_next_s == wp2_rpt);
         almost_empty <= (level_next_s <= AE_THRESH);
         rd_level     <= level_next_s;
         rd_valid     <= accept_s;
         underflow    <= rd_en & empty;
      end
   end

   assign raddr = rbin_r[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed and scoreboard-checked stimulus for fifo_rd_ctrl (ADDR_WIDTH=4,
// AEMPTY_THRESH=2); all outputs are sampled 1 time unit after the RCLK edge.
module tb_fifo_rd_ctrl;

   localparam int AW = 4;

   logic          RCLK = 1'b0;
   logic          RRSTn;
   logic          rd_en;
   logic [AW:0]   wp2_rpt;
   logic [AW-1:0] raddr;
   logic [AW:0]   rpt;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   rd_level;
   logic          rd_valid;
   logic          underflow;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(2)) dut (
      .RCLK(RCLK), .RRSTn(RRSTn), .rd_en(rd_en), .wp2_rpt(wp2_rpt),
      .raddr(raddr), .rpt(rpt), .empty(empty), .almost_empty(almost_empty),
      .rd_level(rd_level), .rd_valid(rd_valid), .underflow(underflow)
   );

   always #5 RCLK = ~RCLK;

   function automatic logic [AW:0] g(input int b);
      logic [AW:0] x;
      x = b[AW:0];
      return x ^ (x >> 1);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge RCLK);
      #1;
   endtask

   task automatic check_state(input string tag, input int e_raddr, input int e_rpt,
                              input int e_empty, input int e_ae, input int e_lvl,
                              input int e_rv, input int e_uf);
      check_eq({tag, ".raddr"}, 32'(raddr), 32'(e_raddr));
      check_eq({tag, ".rpt"}, 32'(rpt), 32'(e_rpt));
      check_eq({tag, ".empty"}, 32'(empty), 32'(e_empty));
      check_eq({tag, ".aempty"}, 32'(almost_empty), 32'(e_ae));
      check_eq({tag, ".level"}, 32'(rd_level), 32'(e_lvl));
      check_eq({tag, ".rvalid"}, 32'(rd_valid), 32'(e_rv));
      check_eq({tag, ".uflow"}, 32'(underflow), 32'(e_uf));
   endtask

   initial begin
      int rb;
      int wb;
      int lvl;
      logic acc;
      logic exp_empty;
      logic [AW:0] prev;

      RRSTn = 1'b1; rd_en = 1'b0; wp2_rpt = 5'b00000;
      #2 RRSTn = 1'b0;
      #1 check_state("reset", 0, 0, 1, 1, 0, 0, 0);
      tick();
      RRSTn = 1'b1;
      tick();
      check_state("post_rst", 0, 0, 1, 1, 0, 0, 0);

      // fill three entries and drain them back to back
      wp2_rpt = 5'b00010;
      tick();
      check_state("fill3", 0, 0, 0, 0, 3, 0, 0);
      rd_en = 1'b1;
      tick();
      check_state("rd1", 1, 5'b00001, 0, 1, 2, 1, 0);
      tick();
      check_state("rd2", 2, 5'b00011, 0, 1, 1, 1, 0);
      tick();
      check_state("rd3", 3, 5'b00010, 1, 1, 0, 1, 0);

      // reads while empty are ignored and flagged
      tick();
      check_state("uf1", 3, 5'b00010, 1, 1, 0, 0, 1);
      tick();
      check_state("uf2", 3, 5'b00010, 1, 1, 0, 0, 1);
      rd_en = 1'b0;
      tick();
      check_state("uf_end", 3, 5'b00010, 1, 1, 0, 0, 0);

      // last-entry read with a simultaneous write pointer advance
      wp2_rpt = g(4);
      tick();
      check_state("lvl1", 3, 5'b00010, 0, 1, 1, 0, 0);
      rd_en = 1'b1; wp2_rpt = g(5);
      tick();
      check_state("simul", 4, 5'b00110, 0, 1, 1, 1, 0);
      tick();
      check_state("drain5", 5, 5'b00111, 1, 1, 0, 1, 0);
      rd_en = 1'b0;

      // two full-depth bursts; the second crosses the pointer wrap 31->0
      for (int pass = 0; pass < 2; pass++) begin
         rb = 5 + 16 * pass;
         wp2_rpt = g(rb + 16);
         tick();
         check_eq("full.level", 32'(rd_level), 32'd16);
         check_eq("full.aempty", 32'(almost_empty), 32'd0);
         check_eq("full.empty", 32'(empty), 32'd0);
         rd_en = 1'b1;
         for (int i = 1; i <= 16; i++) begin
            prev = rpt;
            tick();
            check_eq("burst.raddr", 32'(raddr), 32'((rb + i) % 16));
            check_eq("burst.rpt", 32'(rpt), 32'(g(rb + i)));
            check_eq("burst.onebit", 32'($countones(rpt ^ prev)), 32'd1);
            check_eq("burst.level", 32'(rd_level), 32'(16 - i));
            check_eq("burst.empty", 32'(empty), 32'(i == 16));
         end
         rd_en = 1'b0;
      end
      check_eq("wrap.rpt", 32'(rpt), 32'(5'b00111));

      // asynchronous reset mid-burst at rbin=7
      wp2_rpt = g(12);
      tick();
      rd_en = 1'b1;
      tick();
      tick();
      check_eq("pre_rst.raddr", 32'(raddr), 32'd7);
      #2 RRSTn = 1'b0;
      #1 check_state("mid_rst", 0, 0, 1, 1, 0, 0, 0);
      rd_en = 1'b0; wp2_rpt = 5'b00000;
      tick();
      RRSTn = 1'b1;
      tick();
      check_state("mid_rst_rel", 0, 0, 1, 1, 0, 0, 0);

      // random reads against a monotonic write pointer, checked by a model
      rb = 0; wb = 0; exp_empty = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rd_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0 && (wb - rb) < 16) wb++;
         wp2_rpt = g(wb);
         acc = rd_en & ~exp_empty;
         prev = rpt;
         tick();
         rb += int'(acc);
         lvl = wb - rb;
         exp_empty = (lvl == 0);
         check_eq("rnd.level", 32'(rd_level), 32'(lvl));
         check_eq("rnd.empty", 32'(empty), 32'(exp_empty));
         check_eq("rnd.aempty", 32'(almost_empty), 32'(lvl <= 2));
         check_eq("rnd.rpt", 32'(rpt), 32'(g(rb)));
         check_eq("rnd.raddr", 32'(raddr), 32'(rb % 16));
         check_eq("rnd.rvalid", 32'(rd_valid), 32'(acc));
         check_eq("rnd.onebit", 32'($countones(rpt ^ prev)), 32'(acc));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
